// File: rtl/fetch_queue_if.sv
// Handshake bundle between instruction fetch, the fetch_queue and decode.
// slave = queue side, master = fetch/decode side.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [31:0]      in_pc;
    logic [31:0]      in_inst;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic             out_ready;
    logic [CNT_W-1:0] level;

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, level
    );

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, level
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular {pc, inst} queue between instruction memory and decode; flush drops all entries.
// Optional FETCH_QUEUE_BYPASS_EN: empty queue forwards the offered pair to decode in the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    fetch_queue_if.slave  q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic run;
    logic empty;
    logic bypass;
    logic push;
    logic pop;

    // Handshake and decode-facing outputs; in_ready never looks at out_ready.
    always_comb begin
        run   = !reset && !flush;
        empty = (count_q == '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = empty && q.in_valid;
`else
        bypass = 1'b0;
`endif
        q.in_ready  = run && (count_q != CNT_W'(DEPTH));
        q.out_valid = run && (!empty || bypass);
        q.out_pc    = 32'h0;
        q.out_inst  = NOP_INST;
        if (q.out_valid) begin
            if (bypass) begin
                q.out_pc   = q.in_pc;
                q.out_inst = q.in_inst;
            end else begin
                q.out_pc   = mem_q[rd_ptr_q].pc;
                q.out_inst = mem_q[rd_ptr_q].inst;
            end
        end
        q.level = count_q;
        push    = q.in_valid && q.in_ready;
        pop     = q.out_valid && q.out_ready;
    end

    // Next state; a bypassed pair is written and consumed together, so count holds.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (reset || flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: q.in_pc, inst: q.in_inst};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 2).
// Streaming expectations follow FETCH_QUEUE_BYPASS_EN when it is defined.
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    fetch_queue_if #(.DEPTH(2)) bus ();

    fetch_queue #(.DEPTH(2), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.out_ready = 1'b0;
        step(); step();
        bus.in_valid = 1'b1; bus.in_pc = 32'h40; bus.in_inst = 32'h1111_1111;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.out_inst !== NOP || bus.out_pc !== 32'h0) begin
            errors++; $display("FAIL reset_out got pc %h inst %h want 0 %h", bus.out_pc, bus.out_inst, NOP);
        end
        step();
        reset = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.level !== 2'd0) begin
            errors++; $display("FAIL post_reset got in_ready %b level %0d want 1 0", bus.in_ready, bus.level);
        end
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = 32'h0; bus.in_inst = 32'hC000_0000;
        step();
        bus.in_pc = 32'h4; bus.in_inst = 32'hC000_0001;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.level !== 2'd1 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
            errors++; $display("FAIL fill_one got rdy %b lvl %0d ov %b pc %h want 1 1 1 0",
                               bus.in_ready, bus.level, bus.out_valid, bus.out_pc);
        end
        step();
        bus.in_pc = 32'h8; bus.in_inst = 32'hC000_0002;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.level !== 2'd2) begin
            errors++; $display("FAIL fill_full got rdy %b lvl %0d want 0 2", bus.in_ready, bus.level);
        end
        step();
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.level !== 2'd2 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'hC000_0000) begin
            errors++; $display("FAIL fill_hold got lvl %0d pc %h want 2 0", bus.level, bus.out_pc);
        end
        step();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_pc !== 32'h4 || bus.level !== 2'd1) begin
            errors++; $display("FAIL fill_pop1 got rdy %b pc %h lvl %0d want 1 4 1", bus.in_ready, bus.out_pc, bus.level);
        end
        step();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_pc !== 32'h8 || bus.out_inst !== 32'hC000_0002 || bus.level !== 2'd1) begin
            errors++; $display("FAIL fill_pop2 got pc %h lvl %0d want 8 1", bus.out_pc, bus.level);
        end
        step();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_inst !== NOP || bus.level !== 2'd0) begin
            errors++; $display("FAIL fill_drain got ov %b inst %h lvl %0d want 0 %h 0", bus.out_valid, bus.out_inst, bus.level, NOP);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_pc    = 32'h100 + 32'(4 * k);
            bus.in_inst  = 32'hB000_0000 + 32'(k);
            #1;
`ifdef FETCH_QUEUE_BYPASS_EN
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 + 32'(4 * k) || bus.level !== 2'd0) begin
                errors++; $display("FAIL stream_%0d got ov %b pc %h lvl %0d", k, bus.out_valid, bus.out_pc, bus.level);
            end
`else
            if (k == 0) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_first got ov %b want 0", bus.out_valid); end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 + 32'(4 * (k - 1)) ||
                    bus.out_inst !== 32'hB000_0000 + 32'(k - 1) || bus.level !== 2'd1) begin
                    errors++; $display("FAIL stream_%0d got ov %b pc %h lvl %0d want 1 %h 1",
                                       k, bus.out_valid, bus.out_pc, bus.level, 32'h100 + 32'(4 * (k - 1)));
                end
            end
`endif
            step();
        end
        bus.in_valid = 1'b0;
        #1;
`ifndef FETCH_QUEUE_BYPASS_EN
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h124) begin
            errors++; $display("FAIL stream_last got ov %b pc %h want 1 124", bus.out_valid, bus.out_pc);
        end
        step();
        #1;
`endif
        checks++;
        if (bus.level !== 2'd0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_end got lvl %0d ov %b want 0 0", bus.level, bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        for (int b = 0; b < 7; b++) begin
            bus.out_ready = 1'b0;
            for (int j = 0; j < 2; j++) begin
                bus.in_valid = 1'b1;
                bus.in_pc    = 32'h200 + 32'(4 * (2 * b + j));
                bus.in_inst  = 32'hA000_0000 + 32'(2 * b + j);
                step();
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            for (int j = 0; j < 2; j++) begin
                #1;
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'hA000_0000 + 32'(2 * b + j) ||
                    bus.out_pc !== 32'h200 + 32'(4 * (2 * b + j))) begin
                    errors++; $display("FAIL wrap_%0d got ov %b inst %h want 1 %h",
                                       2 * b + j, bus.out_valid, bus.out_inst, 32'hA000_0000 + 32'(2 * b + j));
                end
                step();
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            bus.in_valid = 1'b1; bus.in_pc = 32'h300 + 32'(4 * j); bus.in_inst = 32'hD000_0000 + 32'(j);
            step();
        end
        flush = 1'b1; bus.in_pc = 32'h308; bus.in_inst = 32'hD000_0002;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.level !== 2'd2) begin
            errors++; $display("FAIL flush_cycle got ov %b rdy %b lvl %0d want 0 0 2", bus.out_valid, bus.in_ready, bus.level);
        end
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.level !== 2'd0 || bus.out_inst !== NOP || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_after got lvl %0d inst %h rdy %b ov %b want 0 %h 1 0",
                               bus.level, bus.out_inst, bus.in_ready, bus.out_valid, NOP);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = 32'h400; bus.in_inst = 32'hE000_0000;
        step();
        reset = 1'b1; bus.in_pc = 32'h404; bus.in_inst = 32'hE000_0001;
        #1;
        checks++;
        if (bus.level !== 2'd1) begin errors++; $display("FAIL rmid_pre got lvl %0d want 1", bus.level); end
        step();
        reset = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.level !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin
            errors++; $display("FAIL rmid_after got lvl %0d ov %b pc %h want 0 0 0", bus.level, bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_empty_pop();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus.level !== 2'd0 || bus.out_inst !== NOP || bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL empty_%0d got lvl %0d inst %h ov %b want 0 %h 0",
                                   k, bus.level, bus.out_inst, bus.out_valid, NOP);
            end
            step();
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = 32'h500; bus.in_inst = 32'hF000_0000;
        step();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h500 || bus.out_inst !== 32'hF000_0000 || bus.level !== 2'd1) begin
            errors++; $display("FAIL empty_ptr got ov %b pc %h lvl %0d want 1 500 1", bus.out_valid, bus.out_pc, bus.level);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_empty_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
